// File: rtl/mem_wb_stage_if.sv
// Data-memory request/ready bus between the MEM stage (master) and the memory (slave).
// Request, address, write data and write enable are combinational from the stage; ready and read data come back the same cycle.
interface mem_wb_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB register: 1 cycle for non-memory ops, 1 + wait states for loads and stores.
// Backpressure: stall_mem freezes upstream while a request waits for dmem_ready, and bubbles enter WB.
module mem_wb_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] pc_ex_mem,
    input  logic [31:0] instruction_ex_mem,
    input  logic        RegWrite_ex_mem,
    input  logic        RegDst_ex_mem,
    input  logic        MemRead_ex_mem,
    input  logic        MemWrite_ex_mem,
    input  logic        MemtoReg_ex_mem,
    input  logic [1:0]  Jump_ex_mem,
    input  logic [31:0] alu_out_ex_mem,
    input  logic [31:0] ram_write_data_ex_mem,
    input  logic [4:0]  rt_ex_mem,
    input  logic [4:0]  rd_ex_mem,
    input  logic        halt_ex_mem,

    mem_wb_stage_if.master dmem,

    output logic        stall_mem,
    output logic        bus_error,

    output logic [31:0] pc_mem_wb,
    output logic [31:0] instruction_mem_wb,
    output logic [31:0] alu_out_mem_wb,
    output logic [31:0] ram_read_data_mem_wb,
    output logic        RegWrite_mem_wb,
    output logic        MemtoReg_mem_wb,
    output logic        halt_mem_wb,
    output logic [1:0]  Jump_mem_wb,
    output logic [4:0]  write_reg_mem_wb
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        bus_error_q, bus_error_d;

    logic [31:0] pc_q, instr_q, alu_q, rdata_q;
    logic        reg_write_q, mem_to_reg_q, halt_q;
    logic [1:0]  jump_q;
    logic [4:0]  write_reg_q;

    logic mem_op;
    logic req;
    logic timeout_hit;
    logic stall;
    logic rd_done;

    assign mem_op      = MemRead_ex_mem | MemWrite_ex_mem;
    assign timeout_hit = (state_q == S_WAIT) && (wait_cnt_q == CNT_LAST) && !dmem.dmem_ready;
    // Request and stall are gated by rst_n so they drop the instant reset asserts.
    assign req         = rst_n && ((state_q == S_WAIT) || mem_op);
    assign stall       = req && !dmem.dmem_ready && !timeout_hit;
    // A store takes priority when both read and write are flagged.
    assign rd_done     = req && dmem.dmem_ready && MemRead_ex_mem && !MemWrite_ex_mem;

    assign dmem.dmem_req   = req;
    assign dmem.dmem_we    = MemWrite_ex_mem;
    assign dmem.dmem_addr  = alu_out_ex_mem;
    assign dmem.dmem_wdata = ram_write_data_ex_mem;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        bus_error_d = bus_error_q;
        case (state_q)
            S_IDLE: begin
                if (mem_op && !dmem.dmem_ready) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = 16'd1;
                end
            end
            S_WAIT: begin
                if (dmem.dmem_ready) begin
                    state_d    = S_IDLE;
                    wait_cnt_d = 16'd0;
                end else if (timeout_hit) begin
                    state_d     = S_IDLE;
                    wait_cnt_d  = 16'd0;
                    bus_error_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= 16'd0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            bus_error_q <= bus_error_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= '0;
            instr_q      <= '0;
            alu_q        <= '0;
            rdata_q      <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            halt_q       <= 1'b0;
            jump_q       <= '0;
            write_reg_q  <= '0;
        end else if (stall) begin
            // Bubble: kill the control fields, leave the data fields as they were.
            instr_q      <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            halt_q       <= 1'b0;
            jump_q       <= '0;
        end else begin
            pc_q         <= pc_ex_mem;
            instr_q      <= instruction_ex_mem;
            alu_q        <= alu_out_ex_mem;
            rdata_q      <= rd_done ? dmem.dmem_rdata : 32'd0;
            reg_write_q  <= RegWrite_ex_mem && !timeout_hit;
            mem_to_reg_q <= MemtoReg_ex_mem;
            halt_q       <= halt_ex_mem;
            jump_q       <= Jump_ex_mem;
            write_reg_q  <= RegDst_ex_mem ? rd_ex_mem : rt_ex_mem;
        end
    end

    assign stall_mem            = stall;
    assign bus_error            = bus_error_q;
    assign pc_mem_wb            = pc_q;
    assign instruction_mem_wb   = instr_q;
    assign alu_out_mem_wb       = alu_q;
    assign ram_read_data_mem_wb = rdata_q;
    assign RegWrite_mem_wb      = reg_write_q;
    assign MemtoReg_mem_wb      = mem_to_reg_q;
    assign halt_mem_wb          = halt_q;
    assign Jump_mem_wb          = jump_q;
    assign write_reg_mem_wb     = write_reg_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed cases then random ops, each checked against a per-instruction latency model.
// The memory answers ready after a chosen number of wait cycles; long latencies exercise the timeout.
module tb_mem_wb_stage;

    localparam int TMO = 16;

    typedef struct {
        logic [31:0] pc, instr, alu, wdata, rdata;
        logic [4:0]  rt, rd;
        logic        rw, rdst, mr, mw, m2r, halt;
        logic [1:0]  jump;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_ex_mem, instruction_ex_mem, alu_out_ex_mem, ram_write_data_ex_mem;
    logic        RegWrite_ex_mem, RegDst_ex_mem, MemRead_ex_mem, MemWrite_ex_mem;
    logic        MemtoReg_ex_mem, halt_ex_mem;
    logic [1:0]  Jump_ex_mem;
    logic [4:0]  rt_ex_mem, rd_ex_mem;
    logic        stall_mem, bus_error;
    logic [31:0] pc_mem_wb, instruction_mem_wb, alu_out_mem_wb, ram_read_data_mem_wb;
    logic        RegWrite_mem_wb, MemtoReg_mem_wb, halt_mem_wb;
    logic [1:0]  Jump_mem_wb;
    logic [4:0]  write_reg_mem_wb;

    mem_wb_stage_if dmem_bus ();

    mem_wb_stage #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .pc_ex_mem             (pc_ex_mem),
        .instruction_ex_mem    (instruction_ex_mem),
        .RegWrite_ex_mem       (RegWrite_ex_mem),
        .RegDst_ex_mem         (RegDst_ex_mem),
        .MemRead_ex_mem        (MemRead_ex_mem),
        .MemWrite_ex_mem       (MemWrite_ex_mem),
        .MemtoReg_ex_mem       (MemtoReg_ex_mem),
        .Jump_ex_mem           (Jump_ex_mem),
        .alu_out_ex_mem        (alu_out_ex_mem),
        .ram_write_data_ex_mem (ram_write_data_ex_mem),
        .rt_ex_mem             (rt_ex_mem),
        .rd_ex_mem             (rd_ex_mem),
        .halt_ex_mem           (halt_ex_mem),
        .dmem                  (dmem_bus.master),
        .stall_mem             (stall_mem),
        .bus_error             (bus_error),
        .pc_mem_wb             (pc_mem_wb),
        .instruction_mem_wb    (instruction_mem_wb),
        .alu_out_mem_wb        (alu_out_mem_wb),
        .ram_read_data_mem_wb  (ram_read_data_mem_wb),
        .RegWrite_mem_wb       (RegWrite_mem_wb),
        .MemtoReg_mem_wb       (MemtoReg_mem_wb),
        .halt_mem_wb           (halt_mem_wb),
        .Jump_mem_wb           (Jump_mem_wb),
        .write_reg_mem_wb      (write_reg_mem_wb)
    );

    always #5 clk = ~clk;

    int  n_cmp = 0;
    int  n_mis = 0;
    logic err_exp = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input op_t o);
        pc_ex_mem             = o.pc;
        instruction_ex_mem    = o.instr;
        alu_out_ex_mem        = o.alu;
        ram_write_data_ex_mem = o.wdata;
        rt_ex_mem             = o.rt;
        rd_ex_mem             = o.rd;
        RegWrite_ex_mem       = o.rw;
        RegDst_ex_mem         = o.rdst;
        MemRead_ex_mem        = o.mr;
        MemWrite_ex_mem       = o.mw;
        MemtoReg_ex_mem       = o.m2r;
        halt_ex_mem           = o.halt;
        Jump_ex_mem           = o.jump;
    endtask

    function automatic op_t rand_op();
        op_t o;
        o.pc    = $urandom;
        o.instr = $urandom | 32'h1;
        o.alu   = $urandom;
        o.wdata = $urandom;
        o.rdata = $urandom;
        o.rt    = 5'($urandom);
        o.rd    = 5'($urandom);
        o.rw    = 1'($urandom);
        o.rdst  = 1'($urandom);
        o.mr    = ($urandom_range(0, 2) == 0);
        o.mw    = ($urandom_range(0, 3) == 0);
        o.m2r   = 1'($urandom);
        o.halt  = ($urandom_range(0, 7) == 0);
        o.jump  = 2'($urandom);
        return o;
    endfunction

    // Starts 1 time unit after a rising edge and returns 1 time unit after the edge that retires the op.
    // lat = number of cycles the memory waits before raising ready.
    task automatic do_op(input op_t o, input int lat, input string nm);
        logic mem, tmo, last;
        int   ncyc;
        mem  = o.mr | o.mw;
        tmo  = mem && (lat >= TMO);
        ncyc = !mem ? 1 : (tmo ? TMO : lat + 1);
        drive(o);
        for (int k = 0; k < ncyc; k++) begin
            last = (k == ncyc - 1);
            dmem_bus.dmem_ready = mem && (k == lat);
            dmem_bus.dmem_rdata = (mem && k == lat) ? o.rdata : $urandom;
            @(negedge clk);
            check_val({nm, ".req"},   32'(dmem_bus.dmem_req), 32'(mem));
            check_val({nm, ".stall"}, 32'(stall_mem), 32'(!last));
            if (mem) begin
                check_val({nm, ".addr"}, dmem_bus.dmem_addr, o.alu);
                check_val({nm, ".we"},   32'(dmem_bus.dmem_we), 32'(o.mw));
                if (o.mw) check_val({nm, ".wdata"}, dmem_bus.dmem_wdata, o.wdata);
            end
            @(posedge clk);
            #1;
            if (!last) begin
                check_val({nm, ".bub_rw"},    32'(RegWrite_mem_wb), 32'd0);
                check_val({nm, ".bub_instr"}, instruction_mem_wb, 32'd0);
            end
        end
        err_exp = err_exp | tmo;
        check_val({nm, ".pc"},    pc_mem_wb, o.pc);
        check_val({nm, ".instr"}, instruction_mem_wb, o.instr);
        check_val({nm, ".alu"},   alu_out_mem_wb, o.alu);
        check_val({nm, ".rdata"}, ram_read_data_mem_wb, (o.mr && !o.mw && !tmo) ? o.rdata : 32'd0);
        check_val({nm, ".rw"},    32'(RegWrite_mem_wb), 32'(o.rw && !tmo));
        check_val({nm, ".m2r"},   32'(MemtoReg_mem_wb), 32'(o.m2r));
        check_val({nm, ".halt"},  32'(halt_mem_wb), 32'(o.halt));
        check_val({nm, ".jump"},  32'(Jump_mem_wb), 32'(o.jump));
        check_val({nm, ".wreg"},  32'(write_reg_mem_wb), 32'(o.rdst ? o.rd : o.rt));
        check_val({nm, ".berr"},  32'(bus_error), 32'(err_exp));
        dmem_bus.dmem_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string nm);
        check_val({nm, ".req"},   32'(dmem_bus.dmem_req), 32'd0);
        check_val({nm, ".stall"}, 32'(stall_mem), 32'd0);
        check_val({nm, ".berr"},  32'(bus_error), 32'd0);
        check_val({nm, ".pc"},    pc_mem_wb, 32'd0);
        check_val({nm, ".instr"}, instruction_mem_wb, 32'd0);
        check_val({nm, ".alu"},   alu_out_mem_wb, 32'd0);
        check_val({nm, ".rdata"}, ram_read_data_mem_wb, 32'd0);
        check_val({nm, ".ctl"},   {27'd0, RegWrite_mem_wb, MemtoReg_mem_wb, halt_mem_wb, Jump_mem_wb}, 32'd0);
        check_val({nm, ".wreg"},  32'(write_reg_mem_wb), 32'd0);
    endtask

    initial begin
        op_t o;
        int  lat;

        // Reset with a load presented: request must stay low.
        rst_n = 1'b0;
        o = '{pc: 32'h100, instr: 32'h8C000040, alu: 32'h40, wdata: 32'h0, rdata: 32'h0,
              rt: 5'd3, rd: 5'd0, rw: 1'b1, rdst: 1'b0, mr: 1'b1, mw: 1'b0, m2r: 1'b1,
              halt: 1'b0, jump: 2'd0};
        drive(o);
        dmem_bus.dmem_ready = 1'b0;
        dmem_bus.dmem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        o = '{pc: 32'h200, instr: 32'h00A52020, alu: 32'h1234, wdata: 32'h0, rdata: 32'h0,
              rt: 5'd7, rd: 5'd5, rw: 1'b1, rdst: 1'b1, mr: 1'b0, mw: 1'b0, m2r: 1'b0,
              halt: 1'b0, jump: 2'd0};
        do_op(o, 0, "alu");

        o = '{pc: 32'h204, instr: 32'h8C030040, alu: 32'h40, wdata: 32'h0, rdata: 32'hCAFEF00D,
              rt: 5'd3, rd: 5'd9, rw: 1'b1, rdst: 1'b0, mr: 1'b1, mw: 1'b0, m2r: 1'b1,
              halt: 1'b0, jump: 2'd0};
        do_op(o, 0, "ld0");

        o.pc = 32'h208; o.alu = 32'h44; o.rdata = 32'h13579BDF; o.rt = 5'd4;
        do_op(o, 3, "ld3");

        o = '{pc: 32'h20C, instr: 32'hAC050080, alu: 32'h80, wdata: 32'hA5A5A5A5, rdata: 32'hDEADBEEF,
              rt: 5'd5, rd: 5'd0, rw: 1'b0, rdst: 1'b0, mr: 1'b0, mw: 1'b1, m2r: 1'b0,
              halt: 1'b0, jump: 2'd0};
        do_op(o, 1, "st1");

        o = '{pc: 32'h210, instr: 32'h8C060100, alu: 32'h100, wdata: 32'h0, rdata: 32'h11112222,
              rt: 5'd6, rd: 5'd0, rw: 1'b1, rdst: 1'b0, mr: 1'b1, mw: 1'b1, m2r: 1'b1,
              halt: 1'b0, jump: 2'd1};
        do_op(o, 2, "rdwr");

        o = '{pc: 32'h214, instr: 32'h8C070200, alu: 32'h200, wdata: 32'h0, rdata: 32'h55555555,
              rt: 5'd7, rd: 5'd0, rw: 1'b1, rdst: 1'b0, mr: 1'b1, mw: 1'b0, m2r: 1'b1,
              halt: 1'b1, jump: 2'd0};
        do_op(o, 1000, "tmo");

        o.pc = 32'h218; o.halt = 1'b0; o.rdata = 32'h77778888;
        do_op(o, TMO - 1, "tmo_edge");

        // Reset asserted while a load is waiting; the held load must then reissue cleanly.
        o = '{pc: 32'h300, instr: 32'h8C080300, alu: 32'h300, wdata: 32'h0, rdata: 32'h0BADF00D,
              rt: 5'd8, rd: 5'd0, rw: 1'b1, rdst: 1'b0, mr: 1'b1, mw: 1'b0, m2r: 1'b1,
              halt: 1'b0, jump: 2'd0};
        drive(o);
        dmem_bus.dmem_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_val("midrst.pre_req",   32'(dmem_bus.dmem_req), 32'd1);
        check_val("midrst.pre_stall", 32'(stall_mem), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        err_exp = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_op(o, 2, "reissue");

        for (int i = 0; i < 80; i++) begin
            o   = rand_op();
            lat = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO, TMO + 4) : $urandom_range(0, 5);
            do_op(o, lat, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
